// File: rtl/disp_pkg.sv
// Shared definitions for the display source selector.
//   - Source-index constants (SRC_PC..SRC_MEM) as driven on src_idx.
//   - FSM state encoding for the show/hold controller.
//   - Default debounce length (20 ms at a 50 MHz clock).
//   - src_mux: picks one of the four 32-bit debug words by index.
package disp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;

  localparam logic [SRC_W-1:0] SRC_PC    = 2'd0;
  localparam logic [SRC_W-1:0] SRC_INSTR = 2'd1;
  localparam logic [SRC_W-1:0] SRC_ALU   = 2'd2;
  localparam logic [SRC_W-1:0] SRC_MEM   = 2'd3;

  localparam int unsigned DEBOUNCE_CYC_DEFAULT = 1000000;

  typedef enum logic {
    StShow = 1'b0,
    StHold = 1'b1
  } disp_state_e;

  function automatic logic [DATA_W-1:0] src_mux(
    input logic [SRC_W-1:0]  idx,
    input logic [DATA_W-1:0] pc,
    input logic [DATA_W-1:0] instr,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem
  );
    logic [DATA_W-1:0] word;
    case (idx)
      SRC_INSTR: word = instr;
      SRC_ALU:   word = alu;
      SRC_MEM:   word = mem;
      default:   word = pc;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle press pulse on each accepted 0->1 transition.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   btn   - raw asynchronous button input
//   level - debounced button level
//   press - one-cycle pulse, coincident with level rising
module btn_debounce
  import disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  // Counter only has to reach DEBOUNCE_CYC-1; the flip happens on the edge
  // that would otherwise take it to DEBOUNCE_CYC.
  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    // Any cycle where the synchronised input agrees with the level restarts
    // the count, so a single bounce back discards all accumulated stability.
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/disp_src_sel.sv
// Display source selector for the 7-segment debug display.
// btn_next cycles the shown word through pc/instr/alu/mem; btn_hold freezes
// the shown word. Both buttons are synchronised and debounced on-chip.
// Build option: define DISP_HOLD_EN to build the hold function; without it
// btn_hold is ignored, the controller always shows and hold_led stays 0.
// Ports:
//   clk       - 50 MHz system clock, rising edge
//   rst_n     - synchronous active-low reset
//   btn_next  - raw button, advance source
//   btn_hold  - raw button, toggle freeze
//   src_pc, src_instr, src_alu, src_mem - candidate 32-bit words
//   data32    - registered word for the display driver
//   src_idx   - selected source (0 pc, 1 instr, 2 alu, 3 mem)
//   hold_led  - high while frozen
module disp_src_sel
  import disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_hold,
  input  logic [DATA_W-1:0] src_pc,
  input  logic [DATA_W-1:0] src_instr,
  input  logic [DATA_W-1:0] src_alu,
  input  logic [DATA_W-1:0] src_mem,
  output logic [DATA_W-1:0] data32,
  output logic [SRC_W-1:0]  src_idx,
  output logic              hold_led
);

  logic next_level, next_press;
  logic hold_press;
  logic unused_levels;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_next_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .level(next_level),
    .press(next_press)
  );

`ifdef DISP_HOLD_EN
  logic hold_level;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_hold_db (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_hold),
    .level(hold_level),
    .press(hold_press)
  );

  assign unused_levels = next_level ^ hold_level;
`else
  assign hold_press    = 1'b0;
  assign unused_levels = next_level ^ btn_hold;
`endif

  disp_state_e       state_q;
  logic [SRC_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic              hold_led_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StShow;
      idx_q      <= SRC_PC;
      data_q     <= '0;
      hold_led_q <= 1'b0;
    end else begin
      // Sampling uses the pre-edge state, so the edge that enters HOLD still
      // captures a fresh word and that word is what stays frozen.
      if (state_q == StShow) begin
        data_q <= src_mux(idx_q, src_pc, src_instr, src_alu, src_mem);
      end
      unique case (state_q)
        StShow: begin
          // A hold press wins; a coincident next press is dropped.
          if (hold_press) begin
            state_q    <= StHold;
            hold_led_q <= 1'b1;
          end else if (next_press) begin
            idx_q <= idx_q + SRC_W'(1);
          end
        end
        StHold: begin
          if (hold_press) begin
            state_q    <= StShow;
            hold_led_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign data32   = data_q;
  assign src_idx  = idx_q;
  assign hold_led = hold_led_q;

endmodule

// File: doc/disp_src_sel.md
DISP_SRC_SEL -- requirements
Module: disp_src_sel

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000, stable-cycle count for button acceptance (20 ms at 50 MHz).
REQ-002 clk  input  1  system clock, 50 MHz board clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 btn_next  input  1  raw, asynchronous push button; advances display source.
REQ-005 btn_hold  input  1  raw, asynchronous push button; toggles freeze of displayed value.
REQ-006 src_pc  input  32  current program counter.
REQ-007 src_instr  input  32  current instruction word.
REQ-008 src_alu  input  32  ALU result.
REQ-009 src_mem  input  32  data-memory read word.
REQ-010 data32  output  32  registered word driven to the 7-segment display driver.
REQ-011 src_idx  output  2  selected source: 0=pc, 1=instr, 2=alu, 3=mem.
REQ-012 hold_led  output  1  high while in HOLD state.

Function
REQ-013 Each raw button SHALL pass a 2-flop synchroniser before any other use.
REQ-014 A debounced level SHALL change only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles; any bounce back SHALL clear the stability counter to 0.
REQ-015 A one-cycle press pulse SHALL be generated on each 0->1 transition of a debounced level; releases generate nothing.
REQ-016 FSM states SHOW and HOLD; press on hold: SHOW->HOLD, HOLD->SHOW; no other transitions.
REQ-017 In SHOW, a next press SHALL increment src_idx modulo 4 (3 wraps to 0); in HOLD, next presses SHALL be ignored.
REQ-018 Same-cycle hold and next presses: hold transition taken, next press discarded.
REQ-019 In SHOW, data32 SHALL register the source selected by src_idx every cycle (1-cycle latency from source or src_idx change).
REQ-020 In HOLD, data32 SHALL retain the value registered on the cycle the SHOW->HOLD transition occurred.
REQ-021 hold_led SHALL be a registered decode of the state (1 in HOLD).
REQ-022 A button held permanently SHALL produce exactly one press pulse.

Reset
REQ-023 While rst_n=0 at a clock edge: data32=0, src_idx=0, hold_led=0, state SHOW, synchronisers, debounced levels and counters 0.
REQ-024 Reset mid-debounce or in HOLD SHALL abort and return to the REQ-023 values; a button still held after reset SHALL be debounced afresh and produce one press.

Configuration
REQ-025 Macro DISP_HOLD_EN: when defined, hold function per REQ-016..REQ-021.
REQ-026 Without DISP_HOLD_EN: btn_hold and its debouncer are not built, state is constantly SHOW, hold_led tied 0, next presses always honoured.

Structure
REQ-027 Package disp_pkg SHALL hold source-index constants (SRC_PC..SRC_MEM), FSM state encoding, and default DEBOUNCE_CYC.
REQ-028 Sub-module btn_debounce (synchroniser, stability counter, debounced level, press pulse) SHALL be instantiated once per button.
REQ-029 Counter width SHALL be derived from DEBOUNCE_CYC; no integer-typed registers.

Verification (bench DEBOUNCE_CYC=4)
REQ-030 Reset release, src_pc=0x00400000 -> data32=0x00400000 on second cycle after release, src_idx=0.
REQ-031 btn_next pulses 1 for 3 cycles then 0 -> no src_idx change; held 10 cycles -> src_idx 0->1 exactly once, data32 follows src_instr one cycle later.
REQ-032 Four accepted next presses from src_idx=3 -> wraps to 0 on the first, ends at 3.
REQ-033 Accepted hold press with src_alu=0x12345678, then src_alu changed to 0 -> data32 stays 0x12345678, hold_led=1, next press ignored; second hold press -> data32=0 next cycle.
REQ-034 hold and next accepted same cycle in SHOW -> state HOLD, src_idx unchanged.
REQ-035 Build without DISP_HOLD_EN, btn_hold held high -> hold_led=0, data32 tracks selected source.
